// File: rtl/matrix_index_sequencer.sv
// Emits the (row, col) index stream for a full or upper-triangle walk of an
// N x N matrix, paced by a valid/ready handshake toward the MAC stage.

module idx_counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      q <= '0;
        else if (clr)  q <= '0;
        else if (load) q <= load_val;
        else if (inc)  q <= q + 1'b1;
    end
endmodule

module matrix_index_sequencer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dim,
    input  logic             tri_walk,
    input  logic             abort,
    input  logic             idx_ready,
    output logic             idx_valid,
    output logic [WIDTH-1:0] row,
    output logic [WIDTH-1:0] col,
    output logic             last,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dim_q;
    logic             tri_q;
    logic [WIDTH-1:0] n_m1;
    logic             accept, run_abort, xfer, row_end, col_end, clr;

    assign n_m1      = dim_q - 1'b1;
    assign row_end   = (row == n_m1);
    assign col_end   = (col == n_m1);
    assign idx_valid = (state_q == RUN);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign last      = idx_valid && row_end && col_end;
    assign xfer      = idx_valid && idx_ready;
    assign accept    = (state_q == IDLE) && start;
    assign run_abort = (state_q == RUN) && abort;
    // Counters park at 0 after the final beat so they never step past N-1.
    assign clr       = accept || run_abort || (xfer && last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            dim_q   <= '0;
            tri_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                dim_q <= dim;
                tri_q <= tri_walk;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (dim != '0) ? RUN : DONE;
            RUN: begin
                if (abort)             state_d = IDLE;
                else if (xfer && last) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    idx_counter #(.WIDTH(WIDTH)) u_row (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .load     (1'b0),
        .load_val ('0),
        .inc      (xfer && col_end),
        .q        (row)
    );

    // On a row wrap the triangular walk restarts at the diagonal of the next row.
    idx_counter #(.WIDTH(WIDTH)) u_col (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .load     (xfer && col_end),
        .load_val (tri_q ? row + 1'b1 : '0),
        .inc      (xfer),
        .q        (col)
    );
endmodule

// File: tb/tb_matrix_index_sequencer.sv
// Scoreboard bench: stimulus pushes the expected index stream, a negedge
// monitor compares every presented beat and pops on transfer.

module tb_matrix_index_sequencer;
    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst, start, tri_walk, abort, idx_ready;
    logic [W-1:0] dim;
    logic         idx_valid, last, busy, done;
    logic [W-1:0] row, col;

    typedef struct packed {
        logic [W-1:0] r;
        logic [W-1:0] c;
        logic         l;
    } beat_t;

    beat_t exp_q[$];
    beat_t mb;
    int    checks = 0, errors = 0, done_cnt = 0, xfer_cnt = 0;
    bit    prev_last_xfer = 1'b0, zero_pending = 1'b0;

    matrix_index_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .dim(dim), .tri_walk(tri_walk),
        .abort(abort), .idx_ready(idx_ready), .idx_valid(idx_valid),
        .row(row), .col(col), .last(last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference stream: row-major, triangular rows start at the diagonal.
    function automatic void push_walk(input int n, input bit t);
        beat_t nb;
        for (int r = 0; r < n; r++)
            for (int c = (t ? r : 0); c < n; c++) begin
                nb.r = W'(r);
                nb.c = W'(c);
                nb.l = (r == n - 1) && (c == n - 1);
                exp_q.push_back(nb);
            end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (done) begin
                done_cnt++;
                chk("done_queue_empty", exp_q.size(), 0);
                chk("done_after_last", int'(prev_last_xfer || zero_pending), 1);
                zero_pending = 1'b0;
            end
            prev_last_xfer = 1'b0;
            if (idx_valid) begin
                if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
                else begin
                    mb = exp_q[0];
                    chk("row", int'(row), int'(mb.r));
                    chk("col", int'(col), int'(mb.c));
                    chk("last", int'(last), int'(mb.l));
                    if (idx_ready) begin
                        void'(exp_q.pop_front());
                        xfer_cnt++;
                        prev_last_xfer = mb.l;
                    end
                end
            end else if (last) chk("last_without_valid", 1, 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_walk(input int n, input bit t, input int ready_pct,
                            input bit toggle, input bit noise, input bit abort_at_start);
        int d0, x0, nb, bound;
        d0 = done_cnt;
        x0 = xfer_cnt;
        nb = t ? n * (n + 1) / 2 : n * n;
        bound = nb * 20 + 20;
        step();
        push_walk(n, t);
        if (n == 0) zero_pending = 1'b1;
        start = 1'b1; dim = W'(n); tri_walk = t; abort = abort_at_start;
        step();
        start = 1'b0; abort = 1'b0;
        dim = W'($urandom); tri_walk = 1'($urandom);
        chk("busy_after_start", int'(busy), 1);
        if (n == 0) begin
            chk("zero_dim_done", int'(done), 1);
            chk("zero_dim_valid", int'(idx_valid), 0);
        end else chk("valid_latency", int'(idx_valid), 1);
        for (int k = 0; k < bound; k++) begin
            if (done_cnt != d0) break;
            idx_ready = toggle ? (k % 3 == 0) : ($urandom_range(99) < ready_pct);
            start = noise && busy && ($urandom_range(3) == 0);
            if (start) dim = W'($urandom_range(1, 7));
            step();
        end
        if (done_cnt == d0) chk("walk_timeout", 0, 1);
        start = 1'b0; idx_ready = 1'b0;
        chk("busy_after_done", int'(busy), 0);
        chk("done_single_cycle", int'(done), 0);
        chk("beat_count", xfer_cnt - x0, nb);
    endtask

    initial begin
        int d0, x0;
        rst = 1'b0; start = 1'b0; dim = '0; tri_walk = 1'b0; abort = 1'b0; idx_ready = 1'b0;
        #1;
        chk("rst_valid", int'(idx_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rowcol", int'({row, col, last}), 0);
        #20 rst = 1'b1;

        run_walk(3, 0, 100, 0, 0, 0);
        run_walk(4, 1, 100, 0, 0, 0);
        run_walk(2, 0, 0, 1, 0, 0);
        run_walk(0, 0, 100, 0, 0, 0);
        run_walk(1, 0, 100, 0, 0, 1);
        run_walk(3, 1, 60, 0, 1, 0);
        run_walk(4, 0, 50, 0, 1, 0);

        // abort after five beats, then a clean follow-up walk
        d0 = done_cnt; x0 = xfer_cnt;
        step();
        push_walk(4, 0);
        start = 1'b1; dim = 4; tri_walk = 1'b0;
        step();
        start = 1'b0; idx_ready = 1'b1;
        for (int k = 0; k < 50 && (xfer_cnt - x0) < 5; k++) step();
        chk("abort_beats_before", xfer_cnt - x0, 5);
        idx_ready = 1'b0; abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_valid", int'(idx_valid), 0);
        chk("abort_row", int'(row), 0);
        chk("abort_col", int'(col), 0);
        chk("abort_busy", int'(busy), 0);
        exp_q.delete();
        repeat (3) step();
        chk("abort_no_done", done_cnt - d0, 0);
        run_walk(2, 0, 100, 0, 0, 0);

        // asynchronous reset in the middle of a walk
        d0 = done_cnt;
        step();
        push_walk(4, 1);
        start = 1'b1; dim = 4; tri_walk = 1'b1;
        step();
        start = 1'b0; idx_ready = 1'b1;
        repeat (3) step();
        #2 rst = 1'b0;
        #1;
        chk("async_rst_valid", int'(idx_valid), 0);
        chk("async_rst_rowcol", int'({row, col, last}), 0);
        chk("async_rst_busy_done", int'({busy, done}), 0);
        exp_q.delete();
        idx_ready = 1'b0;
        #3 rst = 1'b1;
        step();
        chk("post_rst_idle", int'({idx_valid, busy, done}), 0);
        chk("post_rst_no_done", done_cnt - d0, 0);

        for (int i = 0; i < 12; i++)
            run_walk($urandom_range(0, 7), 1'($urandom), $urandom_range(30, 100), 0, 1, 0);
        run_walk(31, 1, 100, 0, 0, 0);
        run_walk(31, 0, 90, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
